// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the per-axis phase encoding, the default 640x480@60 timing constants,
// the total-count helper and the phase sequencing functions used by every
// timing axis and its checker.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        PULSE  = 2'd2,
        BP     = 2'd3
    } phase_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_PULSE  = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_PIXELS = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_PULSE  = 2;
    localparam int DEF_V_BP     = 33;

    // Counts per line (horizontal) or lines per frame (vertical).
    function automatic int axis_total(input int vis, input int fp, input int pulse, input int bp);
        return vis + fp + pulse + bp;
    endfunction

    function automatic int h_total(input int vis, input int fp, input int pulse, input int bp);
        return axis_total(vis, fp, pulse, bp);
    endfunction

    function automatic int v_total(input int vis, input int fp, input int pulse, input int bp);
        return axis_total(vis, fp, pulse, bp);
    endfunction

    // Phase a given count belongs to; used to cross-check the phase FSM.
    function automatic phase_t phase_of(input int cnt, input int vis, input int fp, input int pulse);
        phase_t ph;
        if (cnt < vis) begin
            ph = ACTIVE;
        end else if (cnt < vis + fp) begin
            ph = FP;
        end else if (cnt < vis + fp + pulse) begin
            ph = PULSE;
        end else begin
            ph = BP;
        end
        return ph;
    endfunction

    // Phase to enter after the current count; changes only on the last count of a phase.
    function automatic phase_t next_phase(input phase_t ph, input int cnt, input int vis,
                                          input int fp, input int pulse, input int bp);
        phase_t nxt;
        case (ph)
            ACTIVE:  nxt = (cnt == vis - 1)                    ? FP     : ACTIVE;
            FP:      nxt = (cnt == vis + fp - 1)               ? PULSE  : FP;
            PULSE:   nxt = (cnt == vis + fp + pulse - 1)       ? BP     : PULSE;
            BP:      nxt = (cnt == vis + fp + pulse + bp - 1)  ? ACTIVE : BP;
            default: nxt = ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-chain bundle passed from the chain source through the sprite units.
// t carries coordinates, colour, sync and the active-area flag.
// Modports: out (producer drives t), in (consumer reads t).
interface vga #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    typedef struct packed {
        logic [X_W-1:0] pxl_x;
        logic [Y_W-1:0] pxl_y;
        logic [3:0]     red;
        logic [3:0]     green;
        logic [3:0]     blue;
        logic           hsync;
        logic           vsync;
        logic           active;
    } vga_t;

    vga_t t;

    modport out (output t);
    modport in  (input  t);
endinterface

// File: rtl/timing_axis.sv
// Generic VGA timing axis: a wrapping counter plus the ACTIVE/FP/PULSE/BP
// phase FSM that tracks it. Used once per line (horizontal) and once per
// frame (vertical).
// Ports: clk, rst_n (async active-low), advance (count enable),
//        cnt (current count), phase (current phase), wrap (count is last of axis).
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter  int VIS_LEN   = 640,
    parameter  int FP_LEN    = 16,
    parameter  int PULSE_LEN = 96,
    parameter  int BP_LEN    = 48,
    localparam int TOTAL     = axis_total(VIS_LEN, FP_LEN, PULSE_LEN, BP_LEN),
    localparam int CW        = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] cnt,
    output phase_t        phase,
    output logic          wrap
);

    logic [CW-1:0] cnt_r;
    phase_t        phase_r;

    // Terminal count of the axis; the caller chains the next axis off this.
    assign wrap  = (cnt_r == CW'(TOTAL - 1));
    assign cnt   = cnt_r;
    assign phase = phase_r;

    // Counter and phase register advance together so they can never diverge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            phase_r <= ACTIVE;
        end else if (advance) begin
            cnt_r   <= wrap ? '0 : cnt_r + CW'(1);
            phase_r <= next_phase(phase_r, int'(cnt_r), VIS_LEN, FP_LEN, PULSE_LEN, BP_LEN);
        end
    end

    timing_axis_chk #(
        .VIS_LEN   (VIS_LEN),
        .FP_LEN    (FP_LEN),
        .PULSE_LEN (PULSE_LEN),
        .CW        (CW)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_r),
        .phase (phase_r)
    );

endmodule

// File: rtl/timing_axis_chk.sv
// Consistency checker for one timing axis: the phase register must always
// name the phase that the counter value falls into.
// Ports: clk, rst_n, cnt (axis counter), phase (axis phase register).
module timing_axis_chk
    import vga_timing_pkg::*;
#(
    parameter int VIS_LEN   = 640,
    parameter int FP_LEN    = 16,
    parameter int PULSE_LEN = 96,
    parameter int CW        = 10
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] cnt,
    input phase_t        phase
);

    phase_t exp_phase_s;

    // Phase implied by the current count.
    always_comb begin
        exp_phase_s = phase_of(int'(cnt), VIS_LEN, FP_LEN, PULSE_LEN);
    end

    phase_matches_count: assert property (@(posedge clk) disable iff (!rst_n) phase == exp_phase_s);

endmodule

// File: rtl/vga_chain_source.sv
// Head of the VGA pixel chain. Generates horizontal/vertical timing and
// presents registered coordinates, sync and background colour to the sprite
// chain, plus frame-rate event pulses for game logic and animation.
// Ports: clk, resetN (async active-low), pxl_en (pixel-rate enable),
//        vga_chain_out (pixel bundle), frame_start / vblank_start / anim_pulse
//        (one-clk events), vblank (level, current line outside visible area).
module vga_chain_source
    import vga_timing_pkg::*;
#(
    parameter int          H_PIXELS    = DEF_H_PIXELS,
    parameter int          H_FP        = DEF_H_FP,
    parameter int          H_PULSE     = DEF_H_PULSE,
    parameter int          H_BP        = DEF_H_BP,
    parameter int          V_PIXELS    = DEF_V_PIXELS,
    parameter int          V_FP        = DEF_V_FP,
    parameter int          V_PULSE     = DEF_V_PULSE,
    parameter int          V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int          ANIM_DIV    = 8,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic clk,
    input  logic resetN,
    input  logic pxl_en,
    vga.out      vga_chain_out,
    output logic frame_start,
    output logic vblank_start,
    output logic anim_pulse,
    output logic vblank
);

    localparam int HCW   = $clog2(h_total(H_PIXELS, H_FP, H_PULSE, H_BP));
    localparam int VCW   = $clog2(v_total(V_PIXELS, V_FP, V_PULSE, V_BP));
    localparam int XW    = $clog2(H_PIXELS);
    localparam int YW    = $clog2(V_PIXELS);
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [HCW-1:0]   h_cnt_s;
    logic [VCW-1:0]   v_cnt_s;
    phase_t           h_phase_s;
    phase_t           v_phase_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             active_s;
    logic             at_origin_s;
    logic             at_vblank_s;
    logic [DIV_W-1:0] div_r;

    timing_axis #(
        .VIS_LEN (H_PIXELS), .FP_LEN (H_FP), .PULSE_LEN (H_PULSE), .BP_LEN (H_BP)
    ) u_h_axis (
        .clk (clk), .rst_n (resetN), .advance (pxl_en),
        .cnt (h_cnt_s), .phase (h_phase_s), .wrap (h_wrap_s)
    );

    timing_axis #(
        .VIS_LEN (V_PIXELS), .FP_LEN (V_FP), .PULSE_LEN (V_PULSE), .BP_LEN (V_BP)
    ) u_v_axis (
        .clk (clk), .rst_n (resetN), .advance (h_wrap_s & pxl_en),
        .cnt (v_cnt_s), .phase (v_phase_s), .wrap (v_wrap_s)
    );

    assign active_s    = (h_phase_s == ACTIVE) && (v_phase_s == ACTIVE);
    assign at_origin_s = (h_cnt_s == '0) && (v_cnt_s == '0);
    assign at_vblank_s = (h_cnt_s == '0) && (v_cnt_s == VCW'(V_PIXELS));

    // Frame divider: counts vblank_start events, anim_pulse fires on its zero count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_r <= '0;
        end else if (pxl_en && at_vblank_s) begin
            div_r <= (div_r == DIV_W'(ANIM_DIV - 1)) ? '0 : div_r + DIV_W'(1);
        end
    end

    // Output register: levels follow the presented pixel, events last one clk only.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vga_chain_out.t.pxl_x  <= '0;
            vga_chain_out.t.pxl_y  <= '0;
            vga_chain_out.t.red    <= 4'h0;
            vga_chain_out.t.green  <= 4'h0;
            vga_chain_out.t.blue   <= 4'h0;
            vga_chain_out.t.hsync  <= ~SYNC_ACTIVE;
            vga_chain_out.t.vsync  <= ~SYNC_ACTIVE;
            vga_chain_out.t.active <= 1'b0;
            vblank                 <= 1'b0;
            frame_start            <= 1'b0;
            vblank_start           <= 1'b0;
            anim_pulse             <= 1'b0;
        end else begin
            frame_start  <= pxl_en & at_origin_s;
            vblank_start <= pxl_en & at_vblank_s;
            anim_pulse   <= pxl_en & at_vblank_s & (div_r == '0);
            if (pxl_en) begin
                // Forcing to zero outside the visible area keeps wide counts from aliasing.
                vga_chain_out.t.pxl_x  <= active_s ? h_cnt_s[XW-1:0] : '0;
                vga_chain_out.t.pxl_y  <= active_s ? v_cnt_s[YW-1:0] : '0;
                vga_chain_out.t.red    <= active_s ? BG_COLOR[11:8] : 4'h0;
                vga_chain_out.t.green  <= active_s ? BG_COLOR[7:4]  : 4'h0;
                vga_chain_out.t.blue   <= active_s ? BG_COLOR[3:0]  : 4'h0;
                vga_chain_out.t.hsync  <= (h_phase_s == PULSE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vga_chain_out.t.vsync  <= (v_phase_s == PULSE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vga_chain_out.t.active <= active_s;
                vblank                 <= (v_phase_s != ACTIVE);
            end
        end
    end

endmodule
